exa_crosb_output_vc_arbiter: RTL and testbench
==============================================

# exa_crosb_output_vc_arbiter

Per-output-port scheduler of the crossbar: arbitrates among input ports requesting the output link and tracks per-VC downstream credits. Each request carries the output VC already rewritten by the per-input VC allocation stage. Once an input wins, the link is locked to it until the packet's last beat transfers. Beats are throttled on the credit count of the packet's output VC.

## Interface
- INPUT_NUM, 4, number of requesting input ports
- prio_num, 2, priority classes
- vc_num, 2, VCs per priority class
- MAX_CREDITS, 8, downstream buffer depth per VC (reset credit value)
- CREDIT_WIDTH, `log2(MAX_CREDITS+1)`, credit counter width
- logVcPrio, `log2(prio_num*vc_num)`, output VC index width
- logIn, `log2(INPUT_NUM)`, owner index width

- clk  in  1  single clock; all logic on rising edge
- resetn  in  1  synchronous, active-low reset
- i_req  in  INPUT_NUM  input i has a packet head for this output
- i_req_vc  in  INPUT_NUM*logVcPrio  output VC of input i's packet, slice i
- i_valid  in  INPUT_NUM  input i presents a beat
- i_last  in  INPUT_NUM  beat on input i is the packet's last
- i_credit_ret  in  prio_num*vc_num  one-hot/multi-hot, +1 credit per set VC
- o_grant  out  INPUT_NUM  one-hot owner of the link, registered
- o_grant_vc  out  logVcPrio  output VC of current owner, registered
- o_ready  out  INPUT_NUM  beat accept to owner only
- o_xfer  out  1  beat transferred this cycle
- o_credits  out  prio_num*vc_num*CREDIT_WIDTH  current credit count per VC
- o_credit_err  out  1  sticky: credit returned to a full counter

## Operation
- FSM: IDLE, LOCKED.
- IDLE: eligible(i) = i_req[i] & credits[i_req_vc[i]] != 0. Class(i) = i_req_vc[i] / vc_num. Only eligible requesters of the highest present class compete. Among those, round-robin starting at rr_ptr. On a winner: register o_grant one-hot, o_grant_vc = i_req_vc[winner], rr_ptr = winner+1 mod INPUT_NUM, go to LOCKED. No eligible requester: stay IDLE, rr_ptr unchanged.
- LOCKED: o_ready[owner] = credits[o_grant_vc] != 0; other o_ready bits are 0. xfer = i_valid[owner] & o_ready[owner]. xfer & i_last[owner] makes the next state IDLE and clears o_grant and o_grant_vc. i_req and i_req_vc changes while LOCKED are ignored.
- Credits, per VC v, are updated every cycle in any state:
  - dec = xfer & (v == o_grant_vc); inc = i_credit_ret[v].
  - inc & dec: unchanged.
  - dec only: −1. A dec at 0 cannot occur because o_ready gates it.
  - inc only: +1, saturating at MAX_CREDITS. An inc at MAX sets o_credit_err, which stays set until reset.
- o_xfer = xfer (combinational).

## Timing
- Reset (resetn=0 at a clock edge): state IDLE, o_grant=0, o_grant_vc=0, rr_ptr=0, all credits=MAX_CREDITS, o_credit_err=0. o_ready=0 and o_xfer=0 follow combinationally.
- Reset mid-packet: the lock is dropped on that edge. Credits of in-flight beats are restored to MAX.
- Arbitration latency: request sampled in IDLE at cycle N; o_grant valid from N+1; first beat can transfer at N+1.
- A last beat at cycle M gives IDLE at M+1, with arbitration at M+1 and the new grant at M+2. There is one dead cycle between packets, and it is fixed.
- A single-beat packet (valid & last at N+1) holds the grant for exactly one cycle.
- Credit counts update on the edge after the event. o_ready reflects the registered count, so a credit returned at cycle K enables a beat at K+1.
- Credit 0 while LOCKED: o_ready low, the lock is held, no timeout.

## Test plan
- Reset, then single request: input 2 requests VC1 at cycle 0 → o_grant=4'b0100 and o_grant_vc=1 at cycle 1. A 3-beat packet transfers at cycles 1–3, o_grant=0 at cycle 4, credits[1]=5.
- Round-robin: inputs 0,1,3 request VC0 continuously with 1-beat packets → grant order 0,1,3,0,1,3, with one grant every 2 cycles.
- Priority: input 0 requests VC0 (class 0) and input 3 requests VC2 (class 1) simultaneously → input 3 is granted first, input 0 after input 3's last beat plus one idle cycle.
- Credit stall: credits[VC3] drained to 0 mid-packet → o_ready drops and o_grant holds. i_credit_ret[3] pulse at K → o_ready=1 at K+1 and the beat transfers.
- Simultaneous inc/dec: a transfer on VC1 in the same cycle as i_credit_ret[1] → credits[1] unchanged. i_credit_ret[0] with credits[0]=8 → stays 8 and o_credit_err=1 until reset.
- Ineligible head and reset: input 1 requests VC2 with credits[2]=0 while input 0 requests VC0 → input 0 is granted despite lower class. Assert resetn=0 during input 0's packet → o_grant=0 and all credits=8 next cycle.

Source files
------------

// File: rtl/exa_crosb_output_vc_arbiter.sv
// ---------------------------------------------------------------------------
// exa_crosb_output_vc_arbiter
//
// Per-output-port scheduler of the crossbar. While IDLE it picks one input
// whose head packet has credit on its (already rewritten) output VC. Only
// the highest priority class among eligible requesters competes, and ties
// are broken round-robin. The winner then owns the link until its last beat
// transfers. Beats are throttled on the credit count of the packet's output
// VC, and downstream credit returns are tracked per VC.
//
// Ports:
//   clk, resetn    clock, synchronous active-low reset
//   i_req          per input: packet head waiting for this output
//   i_req_vc       per input: output VC of that packet (slice i)
//   i_valid        per input: beat present
//   i_last         per input: beat is the packet's last
//   i_credit_ret   per VC: one credit returned by downstream
//   o_grant        one-hot link owner (registered)
//   o_grant_vc     output VC of the owner's packet (registered)
//   o_ready        beat accept, owner bit only, gated by credit
//   o_xfer         a beat transfers this cycle
//   o_credits      packed per-VC credit counters
//   o_credit_err   sticky: credit returned to a full counter
// ---------------------------------------------------------------------------
module exa_crosb_output_vc_arbiter #(
  parameter int INPUT_NUM    = 4,
  parameter int prio_num     = 2,
  parameter int vc_num       = 2,
  parameter int MAX_CREDITS  = 8,
  parameter int CREDIT_WIDTH = $clog2(MAX_CREDITS + 1),
  parameter int logVcPrio    = $clog2(prio_num * vc_num),
  parameter int logIn        = $clog2(INPUT_NUM)
) (
  input  logic                                     clk,
  input  logic                                     resetn,
  input  logic [INPUT_NUM-1:0]                     i_req,
  input  logic [INPUT_NUM*logVcPrio-1:0]           i_req_vc,
  input  logic [INPUT_NUM-1:0]                     i_valid,
  input  logic [INPUT_NUM-1:0]                     i_last,
  input  logic [prio_num*vc_num-1:0]               i_credit_ret,
  output logic [INPUT_NUM-1:0]                     o_grant,
  output logic [logVcPrio-1:0]                     o_grant_vc,
  output logic [INPUT_NUM-1:0]                     o_ready,
  output logic                                     o_xfer,
  output logic [prio_num*vc_num*CREDIT_WIDTH-1:0]  o_credits,
  output logic                                     o_credit_err
);

  localparam int NUM_VC = prio_num * vc_num;
  localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = CREDIT_WIDTH'(MAX_CREDITS);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e                  state_q, state_d;
  logic [INPUT_NUM-1:0]    grant_q, grant_d;
  logic [logVcPrio-1:0]    grant_vc_q, grant_vc_d;
  logic [logIn-1:0]        rr_ptr_q, rr_ptr_d;
  logic [CREDIT_WIDTH-1:0] credits_q [NUM_VC];
  logic [CREDIT_WIDTH-1:0] credits_d [NUM_VC];
  logic                    credit_err_q, credit_err_d;

  logic [logVcPrio-1:0]    req_vc [INPUT_NUM];
  logic [INPUT_NUM-1:0]    eligible;
  logic [INPUT_NUM-1:0]    compete;
  logic [NUM_VC-1:0]       vc_dec, vc_inc, vc_err_set;
  logic                    owner_has_credit, xfer, last_xfer;
  logic                    win_found;
  logic [logIn-1:0]        win_idx;
  logic [logIn-1:0]        scan_idx;
  int                      top_class;
  int                      scan_pos;

  // Per-input request decode: a head is eligible only if its VC has credit.
  generate
    for (genvar gi = 0; gi < INPUT_NUM; gi++) begin : g_req
      assign req_vc[gi]   = i_req_vc[gi*logVcPrio +: logVcPrio];
      assign eligible[gi] = i_req[gi] && (credits_q[req_vc[gi]] != '0);
    end
  endgenerate

  // grant_q is all-zero while IDLE, so masking it is enough to keep o_ready
  // confined to the owner of a locked link.
  assign owner_has_credit = (credits_q[grant_vc_q] != '0);
  assign o_ready          = owner_has_credit ? grant_q : '0;
  assign xfer             = |(o_ready & i_valid);
  assign last_xfer        = |(o_ready & i_valid & i_last);

  // Class filter followed by a round-robin scan starting at rr_ptr_q.
  always_comb begin
    top_class = -1;
    for (int i = 0; i < INPUT_NUM; i++) begin
      if (eligible[i] && (int'(req_vc[i]) / vc_num > top_class)) begin
        top_class = int'(req_vc[i]) / vc_num;
      end
    end
    for (int i = 0; i < INPUT_NUM; i++) begin
      compete[i] = eligible[i] && (int'(req_vc[i]) / vc_num == top_class);
    end
    win_found = 1'b0;
    win_idx   = '0;
    scan_pos  = 0;
    scan_idx  = '0;
    for (int k = 0; k < INPUT_NUM; k++) begin
      scan_pos = int'(rr_ptr_q) + k;
      if (scan_pos >= INPUT_NUM) begin
        scan_pos = scan_pos - INPUT_NUM;
      end
      scan_idx = logIn'(scan_pos);
      if (!win_found && compete[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Link ownership: arbitrate only when IDLE, release on the last beat.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_vc_d = grant_vc_q;
    rr_ptr_d   = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d          = LOCKED;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          grant_vc_d       = req_vc[win_idx];
          rr_ptr_d         = (int'(win_idx) == INPUT_NUM - 1) ? '0 : win_idx + logIn'(1);
        end
      end
      LOCKED: begin
        if (last_xfer) begin
          state_d    = IDLE;
          grant_d    = '0;
          grant_vc_d = '0;
        end
      end
      default: begin
        state_d    = IDLE;
        grant_d    = '0;
        grant_vc_d = '0;
      end
    endcase
  end

  // Per-VC credit counters. A return and a consume in the same cycle cancel;
  // a return into a full counter is dropped and flagged instead of wrapping.
  generate
    for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_credit
      assign vc_dec[gi]     = xfer && (grant_vc_q == logVcPrio'(gi));
      assign vc_inc[gi]     = i_credit_ret[gi];
      assign vc_err_set[gi] = vc_inc[gi] && !vc_dec[gi] && (credits_q[gi] == CREDIT_MAX);
      assign credits_d[gi]  =
        (vc_inc[gi] && !vc_dec[gi]) ?
          ((credits_q[gi] == CREDIT_MAX) ? credits_q[gi] : credits_q[gi] + CREDIT_WIDTH'(1)) :
        (vc_dec[gi] && !vc_inc[gi]) ? credits_q[gi] - CREDIT_WIDTH'(1) :
        credits_q[gi];
      assign o_credits[gi*CREDIT_WIDTH +: CREDIT_WIDTH] = credits_q[gi];
    end
  endgenerate

  assign credit_err_d = credit_err_q || (|vc_err_set);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      grant_vc_q   <= '0;
      rr_ptr_q     <= '0;
      credit_err_q <= 1'b0;
      for (int v = 0; v < NUM_VC; v++) begin
        credits_q[v] <= CREDIT_MAX;
      end
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      grant_vc_q   <= grant_vc_d;
      rr_ptr_q     <= rr_ptr_d;
      credit_err_q <= credit_err_d;
      credits_q    <= credits_d;
    end
  end

  assign o_grant      = grant_q;
  assign o_grant_vc   = grant_vc_q;
  assign o_xfer       = xfer;
  assign o_credit_err = credit_err_q;

endmodule

// File: tb/tb_exa_crosb_output_vc_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for exa_crosb_output_vc_arbiter (default parameters: 4 inputs,
// 4 output VCs in 2 classes, 8 credits per VC). Directed scenarios plus a
// randomized run, all compared cycle by cycle against a behavioural model.
// ---------------------------------------------------------------------------
module tb_exa_crosb_output_vc_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  i_req, i_valid, i_last, i_credit_ret;
  logic [7:0]  i_req_vc;
  logic [3:0]  o_grant, o_ready;
  logic [1:0]  o_grant_vc;
  logic        o_xfer, o_credit_err;
  logic [15:0] o_credits;

  int checks   = 0;
  int failures = 0;

  exa_crosb_output_vc_arbiter dut (
    .clk          (clk),
    .resetn       (resetn),
    .i_req        (i_req),
    .i_req_vc     (i_req_vc),
    .i_valid      (i_valid),
    .i_last       (i_last),
    .i_credit_ret (i_credit_ret),
    .o_grant      (o_grant),
    .o_grant_vc   (o_grant_vc),
    .o_ready      (o_ready),
    .o_xfer       (o_xfer),
    .o_credits    (o_credits),
    .o_credit_err (o_credit_err)
  );

  always #5 clk = ~clk;

  // Behavioural model: link owner, output VC, next round-robin start,
  // integer credit counts and the sticky error flag.
  bit m_locked;
  int m_owner;
  int m_ovc;
  int m_rr;
  int m_cred [4];
  bit m_err;

  task automatic model_reset();
    m_locked = 0; m_owner = 0; m_ovc = 0; m_rr = 0; m_err = 0;
    for (int v = 0; v < 4; v++) m_cred[v] = 8;
  endtask

  function automatic int vc_of(int i);
    return int'(i_req_vc[i*2 +: 2]);
  endfunction

  task automatic model_step();
    int  nc [4];
    bit  x;
    int  best;
    int  w;
    int  idx;
    if (!resetn) begin
      model_reset();
      return;
    end
    x = m_locked && (m_cred[m_ovc] > 0) && i_valid[m_owner];
    for (int v = 0; v < 4; v++) begin
      nc[v] = m_cred[v] - ((x && v == m_ovc) ? 1 : 0) + (i_credit_ret[v] ? 1 : 0);
      if (nc[v] > 8) begin
        nc[v] = 8;
        m_err = 1;
      end
    end
    if (!m_locked) begin
      best = -1;
      for (int i = 0; i < 4; i++)
        if (i_req[i] && m_cred[vc_of(i)] > 0 && vc_of(i) / 2 > best) best = vc_of(i) / 2;
      w = -1;
      for (int k = 0; k < 4; k++) begin
        idx = (m_rr + k) % 4;
        if (w < 0 && i_req[idx] && m_cred[vc_of(idx)] > 0 && vc_of(idx) / 2 == best) w = idx;
      end
      if (w >= 0) begin
        m_locked = 1; m_owner = w; m_ovc = vc_of(w); m_rr = (w + 1) % 4;
      end
    end else if (x && i_last[m_owner]) begin
      m_locked = 0;
    end
    for (int v = 0; v < 4; v++) m_cred[v] = nc[v];
  endtask

  // Expected output vector {grant, grant_vc, ready, xfer, err, credits}.
  function automatic logic [27:0] exp_vec();
    logic [3:0]  g, r;
    logic [1:0]  gv;
    logic        x;
    logic [15:0] cr;
    g  = m_locked ? 4'(1 << m_owner) : 4'b0000;
    gv = m_locked ? 2'(m_ovc) : 2'd0;
    r  = (m_locked && m_cred[m_ovc] > 0) ? g : 4'b0000;
    x  = |(r & i_valid);
    for (int v = 0; v < 4; v++) cr[v*4 +: 4] = 4'(m_cred[v]);
    return {g, gv, r, x, m_err, cr};
  endfunction

  function automatic logic [27:0] obs_vec();
    return {o_grant, o_grant_vc, o_ready, o_xfer, o_credit_err, o_credits};
  endfunction

  task automatic clear_inputs();
    i_req = '0; i_req_vc = '0; i_valid = '0; i_last = '0; i_credit_ret = '0;
  endtask

  task automatic set_vc(int i, int vc);
    i_req_vc[i*2 +: 2] = 2'(vc);
  endtask

  task automatic finish_cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    clear_inputs();
    repeat (2) begin
      @(negedge clk);
      finish_cycle();
    end
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    clear_inputs();
    model_reset();
    @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) begin
      i_req = 4'($urandom); i_req_vc = 8'($urandom); i_valid = 4'($urandom);
      i_last = 4'($urandom); i_credit_ret = 4'($urandom);
      @(negedge clk);
      checks++;
      if (obs_vec() !== 28'h0008888) begin
        failures++;
        $display("FAIL reset_state c=%0d got=%h exp=%h", c, obs_vec(), 28'h0008888);
      end
      finish_cycle();
    end
    resetn = 1'b1;
    clear_inputs();
  endtask

  task automatic test_single();
    do_reset();
    for (int c = 0; c <= 5; c++) begin
      clear_inputs();
      if (c == 0) begin i_req[2] = 1'b1; set_vc(2, 1); end
      if (c >= 1 && c <= 3) i_valid[2] = 1'b1;
      if (c == 3) i_last[2] = 1'b1;
      @(negedge clk);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL single_model c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
      if (c == 1) begin
        checks++;
        if ({o_grant, o_grant_vc, o_xfer} !== {4'b0100, 2'd1, 1'b1}) begin
          failures++;
          $display("FAIL single_grant got=%b/%0d/%b exp=0100/1/1", o_grant, o_grant_vc, o_xfer);
        end
      end
      if (c == 4) begin
        checks++;
        if ({o_grant, o_credits[7:4]} !== {4'b0000, 4'd5}) begin
          failures++;
          $display("FAIL single_release got grant=%b cred1=%0d exp grant=0000 cred1=5", o_grant, o_credits[7:4]);
        end
      end
      finish_cycle();
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] ord [6];
    ord = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      clear_inputs();
      i_req = 4'b1011; i_valid = 4'b1011; i_last = 4'b1011;
      @(negedge clk);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL rr_model c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
      checks++;
      if (c % 2 == 1 && c <= 11) begin
        if (o_grant !== ord[(c-1)/2]) begin
          failures++;
          $display("FAIL rr_order c=%0d got=%b exp=%b", c, o_grant, ord[(c-1)/2]);
        end
      end else if (c % 2 == 0) begin
        if (o_grant !== 4'b0000) begin
          failures++;
          $display("FAIL rr_dead_cycle c=%0d got=%b exp=0000", c, o_grant);
        end
      end
      finish_cycle();
    end
  endtask

  task automatic test_priority();
    do_reset();
    for (int c = 0; c <= 6; c++) begin
      clear_inputs();
      i_req = (c == 0) ? 4'b1001 : 4'b0001;
      set_vc(0, 0); set_vc(3, 2);
      i_valid = 4'b1001;
      i_last  = (c == 2) ? 4'b1001 : 4'b0001;
      @(negedge clk);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL prio_model c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
      if (c == 1 || c == 3 || c == 4) begin
        checks++;
        if ((c == 1 && {o_grant, o_grant_vc} !== {4'b1000, 2'd2}) ||
            (c == 3 && o_grant !== 4'b0000) ||
            (c == 4 && {o_grant, o_grant_vc} !== {4'b0001, 2'd0})) begin
          failures++;
          $display("FAIL prio_order c=%0d got grant=%b vc=%0d", c, o_grant, o_grant_vc);
        end
      end
      finish_cycle();
    end
  endtask

  task automatic test_credit_stall();
    do_reset();
    for (int c = 0; c <= 14; c++) begin
      clear_inputs();
      if (c == 0) begin i_req[2] = 1'b1; set_vc(2, 3); end
      if (c >= 1 && c <= 12) i_valid[2] = 1'b1;
      if (c == 12) i_last[2] = 1'b1;
      if (c == 11) i_credit_ret[3] = 1'b1;
      @(negedge clk);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL stall_model c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
      if (c >= 9 && c <= 11) begin
        checks++;
        if ({o_ready, o_grant, o_credits[15:12]} !== {4'b0000, 4'b0100, 4'd0}) begin
          failures++;
          $display("FAIL stall_hold c=%0d got ready=%b grant=%b cred3=%0d exp 0000/0100/0", c, o_ready, o_grant, o_credits[15:12]);
        end
      end
      if (c == 12) begin
        checks++;
        if ({o_ready, o_xfer} !== {4'b0100, 1'b1}) begin
          failures++;
          $display("FAIL stall_resume got ready=%b xfer=%b exp 0100/1", o_ready, o_xfer);
        end
      end
      if (c == 13) begin
        checks++;
        if ({o_grant, o_credits[15:12]} !== {4'b0000, 4'd0}) begin
          failures++;
          $display("FAIL stall_end got grant=%b cred3=%0d exp 0000/0", o_grant, o_credits[15:12]);
        end
      end
      finish_cycle();
    end
  endtask

  task automatic test_inc_dec();
    do_reset();
    for (int c = 0; c <= 7; c++) begin
      clear_inputs();
      if (c == 0) begin i_req[1] = 1'b1; set_vc(1, 1); end
      if (c == 1) begin i_valid[1] = 1'b1; i_last[1] = 1'b1; i_credit_ret = 4'b0010; end
      if (c == 3) i_credit_ret = 4'b0001;
      @(negedge clk);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL incdec_model c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
      if (c == 2) begin
        checks++;
        if ({o_credits[7:4], o_credit_err} !== {4'd8, 1'b0}) begin
          failures++;
          $display("FAIL incdec_cancel got cred1=%0d err=%b exp 8/0", o_credits[7:4], o_credit_err);
        end
      end
      if (c >= 4) begin
        checks++;
        if ({o_credits[3:0], o_credit_err} !== {4'd8, 1'b1}) begin
          failures++;
          $display("FAIL incdec_sticky_err c=%0d got cred0=%0d err=%b exp 8/1", c, o_credits[3:0], o_credit_err);
        end
      end
      finish_cycle();
    end
    do_reset();
    @(negedge clk);
    checks++;
    if (o_credit_err !== 1'b0) begin
      failures++;
      $display("FAIL incdec_err_clear got err=%b exp 0", o_credit_err);
    end
    finish_cycle();
  endtask

  task automatic test_ineligible();
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      clear_inputs();
      resetn = (c == 11) ? 1'b0 : 1'b1;
      i_req[1] = 1'b1; set_vc(1, 2);
      if (c >= 1 && c <= 8) i_valid[1] = 1'b1;
      if (c == 8) i_last[1] = 1'b1;
      if (c >= 9) begin i_req[0] = 1'b1; set_vc(0, 0); end
      if (c >= 10) i_valid[0] = 1'b1;
      @(negedge clk);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL inelig_model c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
      if (c == 10) begin
        checks++;
        if ({o_grant, o_grant_vc, o_credits[11:8]} !== {4'b0001, 2'd0, 4'd0}) begin
          failures++;
          $display("FAIL inelig_grant got grant=%b vc=%0d cred2=%0d exp 0001/0/0", o_grant, o_grant_vc, o_credits[11:8]);
        end
      end
      if (c == 12) begin
        checks++;
        if ({o_grant, o_credits} !== {4'b0000, 16'h8888}) begin
          failures++;
          $display("FAIL inelig_midreset got grant=%b credits=%h exp 0000/8888", o_grant, o_credits);
        end
      end
      finish_cycle();
    end
    resetn = 1'b1;
    clear_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      resetn       = ($urandom_range(0, 99) != 0);
      i_req        = 4'($urandom);
      i_req_vc     = 8'($urandom);
      i_valid      = 4'($urandom) | 4'($urandom);
      i_last       = 4'($urandom) & 4'($urandom);
      i_credit_ret = 4'($urandom) & 4'($urandom) & 4'($urandom);
      @(negedge clk);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL random_model c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
      finish_cycle();
    end
    resetn = 1'b1;
    clear_inputs();
  endtask

  initial begin
    resetn = 1'b0;
    clear_inputs();
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_priority();
    test_credit_stall();
    test_inc_dec();
    test_ineligible();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
